// File: rtl/axi4_lite_reduc_regs_if.sv
// AXI4-Lite bus bundle for the reduction register block.
// The slave modport is the register block; the master modport is the bus driver.
interface axi4_lite_reduc_regs_if #(
    parameter int ADDR_BIT_WIDTH = 32,
    parameter int DATA_BIT_WIDTH = 32
);
    localparam int STRB_W = DATA_BIT_WIDTH / 8;

    logic [ADDR_BIT_WIDTH-1:0] awaddr;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;
    logic [DATA_BIT_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]         wstrb;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    logic [ADDR_BIT_WIDTH-1:0] araddr;
    logic [2:0]                arprot;
    logic                      arvalid;
    logic                      arready;
    logic [DATA_BIT_WIDTH-1:0] rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_reduc_regs.sv
// Four AXI4-Lite RW registers with registered OR/AND/XOR reductions and a popcount.
// Independent write (AW/W in any order) and read FSMs; synchronous active-high reset.
module axi4_lite_reduc_regs #(
    parameter int ADDR_BIT_WIDTH = 32,
    parameter int DATA_BIT_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              sync_rst,
    axi4_lite_reduc_regs_if.slave             bus,
    output logic                              reg_0_or_reduc,
    output logic                              reg_1_and_reduc,
    output logic                              reg_2_xor_reduc,
    output logic [$clog2(DATA_BIT_WIDTH):0]   reg_3_bit_cnt
);
    localparam int STRB_W = DATA_BIT_WIDTH / 8;
    localparam int CNT_W  = $clog2(DATA_BIT_WIDTH) + 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WR_IDLE, WR_HAVE_ADDR, WR_HAVE_DATA, WR_RESP} wr_state_e;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

    wr_state_e                 wr_state_q, wr_state_d;
    rd_state_e                 rd_state_q, rd_state_d;
    logic                      ready_en_q;
    logic [ADDR_BIT_WIDTH-1:0] awaddr_q;
    logic [DATA_BIT_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]         wstrb_q;
    logic [1:0]                bresp_q, bresp_d;
    logic [DATA_BIT_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;
    logic                      or_q, and_q, xor_q;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    logic [DATA_BIT_WIDTH-1:0] regs_cur [4];
    logic                      aw_hs, w_hs, ar_hs;
    logic                      wr_commit;
    logic [ADDR_BIT_WIDTH-1:0] wr_addr;
    logic [DATA_BIT_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]         wr_strb;
    logic                      wr_mapped;
    logic [1:0]                wr_idx;
    logic                      unused_ok;

    function automatic logic is_mapped(input logic [ADDR_BIT_WIDTH-1:0] a);
        return (a >> 4) == '0;
    endfunction

    // Readys are gated by a registered flag so they rise one cycle after reset release.
    assign bus.awready = ready_en_q && (wr_state_q == WR_IDLE || wr_state_q == WR_HAVE_DATA);
    assign bus.wready  = ready_en_q && (wr_state_q == WR_IDLE || wr_state_q == WR_HAVE_ADDR);
    assign bus.arready = ready_en_q && (rd_state_q == RD_IDLE);
    assign bus.bvalid  = (wr_state_q == WR_RESP);
    assign bus.rvalid  = (rd_state_q == RD_RESP);
    assign bus.bresp   = bresp_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

    assign aw_hs = bus.awvalid && bus.awready;
    assign w_hs  = bus.wvalid && bus.wready;
    assign ar_hs = bus.arvalid && bus.arready;

    assign unused_ok = ^{bus.awprot, bus.arprot, bus.araddr[1:0]};

    always_comb begin
        wr_state_d = wr_state_q;
        wr_commit  = 1'b0;
        wr_addr    = awaddr_q;
        wr_data    = wdata_q;
        wr_strb    = wstrb_q;
        bresp_d    = bresp_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_commit = 1'b1;
                    wr_addr   = bus.awaddr;
                    wr_data   = bus.wdata;
                    wr_strb   = bus.wstrb;
                end else if (aw_hs) begin
                    wr_state_d = WR_HAVE_ADDR;
                end else if (w_hs) begin
                    wr_state_d = WR_HAVE_DATA;
                end
            end
            WR_HAVE_ADDR: begin
                if (w_hs) begin
                    wr_commit = 1'b1;
                    wr_data   = bus.wdata;
                    wr_strb   = bus.wstrb;
                end
            end
            WR_HAVE_DATA: begin
                if (aw_hs) begin
                    wr_commit = 1'b1;
                    wr_addr   = bus.awaddr;
                end
            end
            WR_RESP: begin
                if (bus.bready) wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase
        if (wr_commit) begin
            wr_state_d = WR_RESP;
            bresp_d    = is_mapped(wr_addr) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign wr_mapped = is_mapped(wr_addr);
    assign wr_idx    = wr_addr[3:2];

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (ar_hs) begin
                    rd_state_d = RD_RESP;
                    // regs_cur is the pre-edge value, so a same-cycle write reads as old data.
                    if (is_mapped(bus.araddr)) begin
                        rdata_d = regs_cur[bus.araddr[3:2]];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end
                end
            end
            RD_RESP: begin
                if (bus.rready) rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            ready_en_q <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            ready_en_q <= 1'b1;
            bresp_q    <= bresp_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            if (aw_hs) awaddr_q <= bus.awaddr;
            if (w_hs) begin
                wdata_q <= bus.wdata;
                wstrb_q <= bus.wstrb;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_reg
            logic [DATA_BIT_WIDTH-1:0] val_q;
            logic                      sel;
            assign sel = wr_commit && wr_mapped && (wr_idx == 2'(gi));
            always_ff @(posedge clk) begin
                if (sync_rst) begin
                    val_q <= '0;
                end else if (sel) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wr_strb[b]) val_q[8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
            assign regs_cur[gi] = val_q;
        end
    endgenerate

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < DATA_BIT_WIDTH; i++) begin
            cnt_d = cnt_d + CNT_W'(regs_cur[3][i]);
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            or_q  <= 1'b0;
            and_q <= 1'b0;
            xor_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            or_q  <= |regs_cur[0];
            and_q <= &regs_cur[1];
            xor_q <= ^regs_cur[2];
            cnt_q <= cnt_d;
        end
    end

    assign reg_0_or_reduc  = or_q;
    assign reg_1_and_reduc = and_q;
    assign reg_2_xor_reduc = xor_q;
    assign reg_3_bit_cnt   = cnt_q;
endmodule

// File: tb/tb_axi4_lite_reduc_regs.sv
// Self-checking bench: reset/corner-case sequences, a vector table and random
// traffic compared against a byte-array model of the four registers.
module tb_axi4_lite_reduc_regs;
    logic       clk = 1'b0;
    logic       sync_rst = 1'b1;
    logic       or0, and1, xor2;
    logic [5:0] cnt3;

    axi4_lite_reduc_regs_if #(.ADDR_BIT_WIDTH(32), .DATA_BIT_WIDTH(32)) bus ();

    axi4_lite_reduc_regs #(.ADDR_BIT_WIDTH(32), .DATA_BIT_WIDTH(32)) dut (
        .clk             (clk),
        .sync_rst        (sync_rst),
        .bus             (bus),
        .reg_0_or_reduc  (or0),
        .reg_1_and_reduc (and1),
        .reg_2_xor_reduc (xor2),
        .reg_3_bit_cnt   (cnt3)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] mdl [4];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          mode;
        int          gap;
        logic [1:0]  exp_bresp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) mdl[i] = '0;
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output logic [1:0] resp);
        logic [1:0] idx;
        if (addr >= 32'h10) begin
            resp = 2'b10;
        end else begin
            idx = addr[3:2];
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
            resp = 2'b00;
        end
    endtask

    task automatic model_read(input logic [31:0] addr, output logic [31:0] data,
                              output logic [1:0] resp);
        logic [1:0] idx;
        idx = addr[3:2];
        if (addr >= 32'h10) begin
            data = '0; resp = 2'b10;
        end else begin
            data = mdl[idx]; resp = 2'b00;
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_or0"},  64'(or0),  64'(mdl[0] != 0));
        chk({tag, "_and1"}, 64'(and1), 64'(mdl[1] == 32'hFFFF_FFFF));
        chk({tag, "_xor2"}, 64'(xor2), 64'($countones(mdl[2]) % 2));
        chk({tag, "_cnt3"}, 64'(cnt3), 64'($countones(mdl[3])));
    endtask

    task automatic do_reset(input int n);
        clear_inputs();
        sync_rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        sync_rst = 1'b0;
        model_clear();
        tick();
    endtask

    task automatic wait_aw_w(input string tag);
        int cyc = 0;
        logic aw_f, w_f;
        while ((bus.awvalid || bus.wvalid) && cyc < 20) begin
            aw_f = bus.awvalid && bus.awready;
            w_f  = bus.wvalid && bus.wready;
            tick();
            if (aw_f) bus.awvalid = 1'b0;
            if (w_f)  bus.wvalid  = 1'b0;
            cyc++;
        end
        chk({tag, "_hs_done"}, 64'(bus.awvalid || bus.wvalid), 64'd0);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
    endtask

    // mode 0: AW+W together; 1: AW, gap cycles, then W; 2: W, gap cycles, then AW
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int mode, input int gap, output logic [1:0] resp);
        int lat = 0;
        string tag;
        tag = $sformatf("wr_%08h", addr);
        bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
        if (mode != 2) bus.awvalid = 1'b1;
        if (mode != 1) bus.wvalid  = 1'b1;
        wait_aw_w(tag);
        if (mode != 0) begin
            for (int g = 0; g < gap; g++) begin
                if (mode == 1) chk({tag, "_awready_stall"}, 64'(bus.awready), 64'd0);
                else           chk({tag, "_wready_stall"},  64'(bus.wready),  64'd0);
                tick();
            end
            if (mode == 1) bus.wvalid = 1'b1;
            else           bus.awvalid = 1'b1;
            wait_aw_w(tag);
        end
        while (!bus.bvalid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_b_latency"}, 64'(lat), 64'd0);
        resp = bus.bvalid ? bus.bresp : 2'b11;
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        chk({tag, "_bvalid_clear"}, 64'(bus.bvalid), 64'd0);
        $display("WR addr=%08h data=%08h strb=%h mode=%0d gap=%0d bresp=%0d", addr, data, strb, mode, gap, resp);
    endtask

    task automatic do_read(input logic [31:0] addr, input int hold,
                           input logic [31:0] exp_d, input logic [1:0] exp_r);
        int cyc = 0;
        logic f;
        string tag;
        tag = $sformatf("rd_%08h", addr);
        bus.araddr = addr;
        bus.arvalid = 1'b1;
        while (bus.arvalid && cyc < 20) begin
            f = bus.arready;
            tick();
            if (f) bus.arvalid = 1'b0;
            cyc++;
        end
        chk({tag, "_ar_hs_done"}, 64'(bus.arvalid), 64'd0);
        bus.arvalid = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            chk({tag, "_rvalid"},  64'(bus.rvalid),  64'd1);
            chk({tag, "_rdata"},   64'(bus.rdata),   64'(exp_d));
            chk({tag, "_rresp"},   64'(bus.rresp),   64'(exp_r));
            chk({tag, "_arready"}, 64'(bus.arready), 64'd0);
            if (h < hold) tick();
        end
        $display("RD addr=%08h hold=%0d rdata=%08h rresp=%0d", addr, hold, bus.rdata, bus.rresp);
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        chk({tag, "_rvalid_clear"}, 64'(bus.rvalid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, expected end of test first");
        $fatal(1);
    end

    initial begin
        logic [1:0]  resp, eresp;
        logic [31:0] edata, addr, data;
        logic [3:0]  strb;

        vecs[0] = '{32'h0,  32'h0000_0100, 4'hF, 0, 0, 2'b00, 32'h0000_0100, 2'b00};
        vecs[1] = '{32'h4,  32'hAABB_CCDD, 4'h3, 1, 2, 2'b00, 32'h0000_CCDD, 2'b00};
        vecs[2] = '{32'h5,  32'h1122_3344, 4'hC, 2, 1, 2'b00, 32'h1122_CCDD, 2'b00};
        vecs[3] = '{32'h8,  32'h0000_0003, 4'hF, 0, 0, 2'b00, 32'h0000_0003, 2'b00};
        vecs[4] = '{32'hC,  32'hFFFF_FFFF, 4'h0, 1, 0, 2'b00, 32'h0000_0000, 2'b00};
        vecs[5] = '{32'h20, 32'hDEAD_BEEF, 4'hF, 2, 3, 2'b10, 32'h0000_0000, 2'b10};
        vecs[6] = '{32'hE,  32'hFFFF_FFFF, 4'h4, 0, 0, 2'b00, 32'h00FF_0000, 2'b00};

        // Reset held three cycles, then released
        clear_inputs();
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", 64'(bus.awready), 64'd0);
        chk("rst_wready",  64'(bus.wready),  64'd0);
        chk("rst_arready", 64'(bus.arready), 64'd0);
        chk("rst_bvalid",  64'(bus.bvalid),  64'd0);
        chk("rst_rvalid",  64'(bus.rvalid),  64'd0);
        chk("rst_bresp",   64'(bus.bresp),   64'd0);
        chk("rst_rresp",   64'(bus.rresp),   64'd0);
        chk("rst_rdata",   64'(bus.rdata),   64'd0);
        check_status("rst");
        sync_rst = 1'b0;
        @(negedge clk);
        chk("release_awready_early", 64'(bus.awready), 64'd0);
        chk("release_arready_early", 64'(bus.arready), 64'd0);
        tick();
        chk("release_awready", 64'(bus.awready), 64'd1);
        chk("release_wready",  64'(bus.wready),  64'd1);
        chk("release_arready", 64'(bus.arready), 64'd1);

        // All-ones to REG1 with AW and W together
        bus.awaddr = 32'h4; bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("s22_bvalid", 64'(bus.bvalid), 64'd1);
        chk("s22_bresp",  64'(bus.bresp),  64'd0);
        chk("s22_and1_not_yet", 64'(and1), 64'd0);
        tick();
        chk("s22_and1", 64'(and1), 64'd1);
        chk("s22_bvalid_hold", 64'(bus.bvalid), 64'd1);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        chk("s22_bvalid_clear", 64'(bus.bvalid), 64'd0);
        $display("WR addr=00000004 data=ffffffff strb=f mode=0 gap=0 bresp=%0d", bus.bresp);
        model_write(32'h4, 32'hFFFF_FFFF, 4'hF, eresp);

        // W three cycles ahead of AW to REG3
        do_write(32'hC, 32'h0000_00F0, 4'h1, 2, 3, resp);
        model_write(32'hC, 32'h0000_00F0, 4'h1, eresp);
        chk("s23_bresp", 64'(resp), 64'(eresp));
        chk("s23_cnt3", 64'(cnt3), 64'd4);
        check_status("s23");

        // Unmapped write and read
        do_write(32'h10, 32'h1234_5678, 4'hF, 0, 0, resp);
        chk("s24_bresp", 64'(resp), 64'd2);
        for (int i = 0; i < 4; i++) begin
            model_read(32'(i * 4), edata, eresp);
            do_read(32'(i * 4), 0, edata, eresp);
        end
        do_read(32'h10, 0, 32'h0, 2'b10);
        check_status("s24");

        // Read held off by rready for five cycles
        do_write(32'h8, 32'h1, 4'hF, 0, 0, resp);
        model_write(32'h8, 32'h1, 4'hF, eresp);
        chk("s25_bresp", 64'(resp), 64'(eresp));
        do_read(32'h8, 5, 32'h1, 2'b00);
        chk("s25_xor2", 64'(xor2), 64'd1);

        // Captured AW discarded by reset; later lone W must not commit
        do_reset(2);
        bus.awaddr = 32'h0; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        chk("s26_aw_captured", 64'(bus.awready), 64'd0);
        sync_rst = 1'b1;
        tick();
        sync_rst = 1'b0;
        tick();
        chk("s26_awready_idle", 64'(bus.awready), 64'd1);
        bus.wdata = 32'hFF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("s26_no_bvalid", 64'(bus.bvalid), 64'd0);
            tick();
        end
        chk("s26_or0", 64'(or0), 64'd0);
        do_read(32'h0, 0, 32'h0, 2'b00);

        // Vector table from a clean reset
        do_reset(2);
        for (int i = 0; i < 7; i++) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].mode, vecs[i].gap, resp);
            model_write(vecs[i].addr, vecs[i].data, vecs[i].strb, eresp);
            chk($sformatf("vec%0d_bresp", i), 64'(resp), 64'(vecs[i].exp_bresp));
            do_read(vecs[i].addr, i % 3, vecs[i].exp_rdata, vecs[i].exp_rresp);
        end
        chk("vec_or0",  64'(or0),  64'd1);
        chk("vec_and1", 64'(and1), 64'd0);
        chk("vec_xor2", 64'(xor2), 64'd0);
        chk("vec_cnt3", 64'(cnt3), 64'd8);

        // Same-edge write and read of REG0 returns the old value
        do_write(32'h0, 32'hA5A5_0000, 4'hF, 0, 0, resp);
        model_write(32'h0, 32'hA5A5_0000, 4'hF, eresp);
        bus.awaddr = 32'h0; bus.wdata = 32'h0000_1234; bus.wstrb = 4'hF; bus.araddr = 32'h0;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        chk("coll_rvalid", 64'(bus.rvalid), 64'd1);
        chk("coll_rdata",  64'(bus.rdata),  64'hA5A5_0000);
        chk("coll_bvalid", 64'(bus.bvalid), 64'd1);
        bus.bready = 1'b1; bus.rready = 1'b1;
        tick();
        bus.bready = 1'b0; bus.rready = 1'b0;
        $display("WR+RD collision addr=00000000 data=00001234");
        model_write(32'h0, 32'h0000_1234, 4'hF, eresp);
        do_read(32'h0, 0, 32'h0000_1234, 2'b00);

        // Random traffic against the model
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) < 8) addr = 32'($urandom_range(0, 15));
            else                          addr = $urandom() | 32'h10;
            data = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
            strb = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                do_write(addr, data, strb, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), resp);
                model_write(addr, data, strb, eresp);
                chk($sformatf("rand%0d_bresp", n), 64'(resp), 64'(eresp));
                check_status($sformatf("rand%0d", n));
            end else begin
                model_read(addr, edata, eresp);
                do_read(addr, int'($urandom_range(0, 2)), edata, eresp);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
